// File: rtl/pdm_pkg.sv
// pdm_pkg: shared FSM state type and parameter range limits for the PDM DDR deserializer
package pdm_pkg;
  typedef enum logic [1:0] {IDLE, FLUSH, RUN} state_t;
  localparam int NUM_LINES_MIN = 1;
  localparam int NUM_LINES_MAX = 4;
  localparam int WORD_W_MIN = 4;
  localparam int WORD_W_MAX = 32;
endpackage

// File: rtl/pdm_ddr_cap.sv
// pdm_ddr_cap: one PDM line, rising/falling-edge sampling retimed to rising clk (PDM_DESER_LR_SWAP_EN swaps R/L)
module pdm_ddr_cap (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic r,
  output logic l
);
  logic rise_q, fall_q, rise_rt, fall_rt;
  // rising-edge sample
  always_ff @(posedge clk or posedge rst)
    if (rst) rise_q <= 1'b0;
    else rise_q <= din;
  // falling-edge sample
  always_ff @(negedge clk or posedge rst)
    if (rst) fall_q <= 1'b0;
    else fall_q <= din;
  // retime both samples onto the rising edge so they reach the shifter together
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rise_rt <= 1'b0;
      fall_rt <= 1'b0;
    end else begin
      rise_rt <= rise_q;
      fall_rt <= fall_q;
    end
`ifdef PDM_DESER_LR_SWAP_EN
  assign r = fall_rt;
  assign l = rise_rt;
`else
  assign r = rise_rt;
  assign l = fall_rt;
`endif
endmodule

// File: rtl/pdm_ddr_deser.sv
// pdm_ddr_deser: multi-line DDR PDM deserializer with flush, word handshake and sticky overflow (option PDM_DESER_LR_SWAP_EN)
module pdm_ddr_deser
  import pdm_pkg::*;
#(
  parameter int NUM_LINES = 2,
  parameter int WORD_W = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_LINES-1:0]          din,
  input  logic                          en,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [2*NUM_LINES*WORD_W-1:0] out_data,
  input  logic                          ovf_clr,
  output logic                          ovf
);
  localparam int CH = 2 * NUM_LINES;
  localparam int CW = $clog2(WORD_W);
  logic [CH-1:0] bits;
  logic [CH*WORD_W-1:0] sr, nxt;
  state_t state;
  logic flush_cnt;
  logic [CW-1:0] cnt;
  logic shift, last;
  for (genvar i = 0; i < NUM_LINES; i++) begin : g_cap
    pdm_ddr_cap u_cap (
      .clk(clk),
      .rst(rst),
      .din(din[i]),
      .r(bits[2*i]),
      .l(bits[2*i+1])
    );
  end
  for (genvar i = 0; i < CH; i++) begin : g_nxt
    assign nxt[i*WORD_W +: WORD_W] = {sr[i*WORD_W +: WORD_W-1], bits[i]};
  end
  assign shift = en && state == RUN;
  assign last = shift && cnt == CW'(WORD_W - 1);
  // capture FSM: flush the retime pipeline, then shift whole words; en low discards the partial word
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      flush_cnt <= 1'b0;
      cnt <= '0;
      sr <= '0;
    end else if (!en) begin
      state <= IDLE;
      flush_cnt <= 1'b0;
      cnt <= '0;
      sr <= '0;
    end else
      case (state)
        IDLE: begin
          state <= FLUSH;
          flush_cnt <= 1'b0;
        end
        FLUSH: begin
          flush_cnt <= 1'b1;
          state <= flush_cnt ? RUN : FLUSH;
        end
        RUN: begin
          sr <= nxt;
          cnt <= last ? '0 : cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
  // output word register with valid/ready handshake and sticky overflow (set beats clear)
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      ovf <= 1'b0;
    end else begin
      if (last) out_data <= nxt;
      out_valid <= last | (out_valid & ~out_ready);
      ovf <= (last & out_valid & ~out_ready) | (ovf & ~ovf_clr);
    end
endmodule

// File: doc/pdm_ddr_deser.md
PDM_DDR_DESER -- requirements
Module: pdm_ddr_deser

Interface
REQ-001 SHALL have parameter NUM_LINES, default 2: number of PDM data lines, range 1..4.
REQ-002 SHALL have parameter WORD_W, default 16: bits per output word per channel, range 4..32.
REQ-003 SHALL have port clk, input, 1: PDM bit clock; the single clock.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port din, input, NUM_LINES: PDM data lines, two channels per line time-multiplexed on the clk edges.
REQ-006 SHALL have port en, input, 1: capture enable.
REQ-007 SHALL have port out_ready, input, 1: downstream accepts the output word.
REQ-008 SHALL have port out_valid, output, 1: out_data holds an unconsumed word set.
REQ-009 SHALL have port out_data, output, 2*NUM_LINES*WORD_W: packed words; line k R at [2k*WORD_W +: WORD_W], L at [(2k+1)*WORD_W +: WORD_W].
REQ-010 SHALL have port ovf_clr, input, 1: clears the sticky overflow flag.
REQ-011 SHALL have port ovf, output, 1: sticky overflow flag.

Function
REQ-012 SHALL sample each din line on rising clk into R and on falling clk into L, then retime both to rising clk; both channels SHALL have 2 rising-edge latency from the sampling edge to the shift stage.
REQ-013 SHALL run an FSM with states IDLE, FLUSH, RUN; reset state is IDLE.
REQ-014 IDLE->FLUSH when en=1; FLUSH SHALL last exactly 2 cycles (discarding pipeline contents) then go to RUN.
REQ-015 Any state ->IDLE on the cycle en=0; the partial word and bit counter SHALL be discarded, and a pending out_valid word SHALL be kept.
REQ-016 In RUN, each cycle SHALL shift one retimed bit per channel into its shift register, MSB first (first bit lands in bit WORD_W-1).
REQ-017 The bit counter SHALL count 0..WORD_W-1 in RUN and wrap to 0; on the cycle it equals WORD_W-1 the completed words of all channels SHALL load into out_data the next cycle, with out_valid=1.
REQ-018 Handshake: a word is consumed on a rising edge with out_valid=1 and out_ready=1; out_valid SHALL then drop unless a new load occurs on the same edge.
REQ-019 Load while out_valid=1 and out_ready=0: the new word SHALL overwrite out_data, out_valid SHALL stay 1, and ovf SHALL be set.
REQ-020 Load and consume on the same edge SHALL NOT set ovf.
REQ-021 ovf SHALL stay set until ovf_clr=1; if ovf_clr and a new overflow coincide, ovf SHALL be 1 (set wins).
REQ-022 out_data SHALL change only on load; it SHALL hold its value otherwise, including in IDLE.

Reset
REQ-023 While rst=1: FSM=IDLE; all capture, retime and shift registers and the bit counter =0; out_valid=0; out_data=0; ovf=0.
REQ-024 Reset mid-word SHALL discard all partial data; no word SHALL be emitted until a full WORD_W bits have been captured after FLUSH.

Configuration
REQ-025 Macro PDM_DESER_LR_SWAP_EN: when defined, the falling-edge sample SHALL be R and the rising-edge sample L, and the retime latency SHALL be unchanged.
REQ-026 Without PDM_DESER_LR_SWAP_EN, the mapping SHALL be as in REQ-012.

Structure
REQ-027 A shared package pdm_pkg SHALL hold the FSM state typedef and the NUM_LINES/WORD_W range limits.
REQ-028 Per-line capture SHALL be sub-module pdm_ddr_cap (one line: dual-edge sample and retime), instantiated NUM_LINES times.

Verification
REQ-029 NUM_LINES=1, WORD_W=8, en=1: drive L bits 0xA5 and R bits 0x3C after FLUSH -> out_valid=1 with out_data=0xA53C.
REQ-030 out_ready held at 0 across two words -> ovf=1 and out_data = second word; pulse ovf_clr -> ovf=0.
REQ-031 out_ready=1 on the same edge as the next load -> out_valid stays 1 with the new word and ovf=0.
REQ-032 en dropped after 5 of 8 bits, then re-asserted -> 2-cycle FLUSH, then a full 8-bit word is emitted with no stale bits.
REQ-033 rst pulsed mid-word -> all outputs are 0 immediately (asynchronous), and the first word after reset is correct.
REQ-034 Build with PDM_DESER_LR_SWAP_EN and repeat REQ-029 -> out_data=0x3CA5.
